updw_monitor: RTL
=================

# updw_monitor

Receive-side checker for the 3-bit up/down triangle count (0,1,…,7,6,…,1,0,1,…; period 14). It samples the count stream each enabled cycle, acquires direction, declares lock after a run of consistent steps, and then flags every deviation. It reports peaks, troughs, completed periods and error counts, so test benches and on-board debug logic can confirm that a count source is healthy.

## Interface
- WIDTH, 3, count width; MAX = 2^WIDTH-1
- LOCK_CNT, 4, consecutive valid transitions required to lock (≥1)
- CNT_W, 8, width of period_count and err_count
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high; one clock, one reset domain
- en  in  1  sample qualifier; din examined only when en=1
- din  in  WIDTH  observed count value
- locked  out  1  level; sequence tracked and consistent
- dir_up  out  1  level; current tracked direction (1=up), meaningful when locked
- err  out  1  one-cycle pulse; mismatch while locked
- peak  out  1  one-cycle pulse; MAX accepted while locked
- trough  out  1  one-cycle pulse; 0 accepted while locked
- period_count  out  CNT_W  troughs accepted while locked; saturates at all-ones
- err_count  out  CNT_W  err pulses since reset; saturates at all-ones

## Operation
- Internal registers: state, prev[WIDTH], dir, match_cnt (≥ clog2(LOCK_CNT+1) bits).
- expected(prev,dir): if dir up: prev==MAX → MAX-1 (dir becomes down), else prev+1. If dir down: prev==0 → 1 (dir becomes up), else prev-1.
- States (all transitions on an en=1 cycle only; en=0 holds everything, pulses 0):
  - HUNT: prev←din; → ACQ.
  - ACQ: prev==0 and din==1 → dir=up. prev==MAX and din==MAX-1 → dir=down. Otherwise din==prev+1 → up; din==prev-1 → down. On success: match_cnt←1, → TRACK (or LOCKED if LOCK_CNT==1). Otherwise stay in ACQ, match_cnt←0. prev←din always.
  - TRACK: din==expected → update dir per turnaround, match_cnt+1; reaching LOCK_CNT → LOCKED. Mismatch → ACQ, match_cnt←0, no err. prev←din always.
  - LOCKED: din==expected → update dir, stay. Mismatch → err=1, err_count+1 (saturating), → ACQ, match_cnt←0. prev←din always.
- peak/trough/period_count act only on matching samples accepted while the state before the edge is LOCKED. A mismatching 0 or MAX gives no trough or peak.
- Repeated value (din==prev) is a mismatch. Turnaround at 0/MAX is the only direction change allowed.
- locked=1 exactly when state==LOCKED; dir_up mirrors dir.

## Timing
- All outputs are registered; response appears in the cycle after the edge that samples din (latency 1).
- Reset (any cycle, including mid-lock): at the next posedge state=HUNT, prev=0, dir=0, match_cnt=0, all outputs 0 (locked, dir_up, err, peak, trough, period_count, err_count).
- Lock timing from HUNT with clean input and en=1: LOCK_CNT+1 samples are needed. locked rises after the edge sampling sample index LOCK_CNT (0-based).
- err, peak and trough are high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Wrap: turnaround at MAX and at 0 is a valid step, not an error. Counters never wrap.
- en gaps are transparent: the sequence is judged on enabled samples only.

## Test plan
- Reset, en=1, din = 0,1,2,3,4,… → locked=0 through sample 3; locked=1 and dir_up=1 after the sample-4 edge; err stays 0.
- Locked, feed 5,6,7,6,5 → peak pulses once after the 7; dir_up falls after the 6 that follows; no err.
- Run 3 full periods locked → trough pulses at each 0 and period_count=3. Force 255+ troughs with CNT_W=8 → period_count holds at 255.
- Locked at 4 going up, inject 2 → err=1 for one cycle, err_count=1, locked=0. Then 3,4,5,6 (up) → relocks after the 4th valid step.
- Locked, en toggled 0/1 with din garbage when en=0 → no err, locked held, outputs unchanged during en=0.
- Locked with counts nonzero, assert reset for one cycle mid-period → every output 0 the next cycle; reacquires per the lock-timing rule.

Source files
------------

// File: rtl/updw_monitor.sv
// Receive-side checker for an up/down triangle count (0..MAX..0).
// It acquires the direction, locks after LOCK_CNT consistent steps, then flags deviations and reports peaks/troughs.
module updw_monitor #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic             locked,
  output logic             dir_up,
  output logic             err,
  output logic             peak,
  output logic             trough,
  output logic [CNT_W-1:0] period_count,
  output logic [CNT_W-1:0] err_count
);

  // state  | meaning
  // HUNT   | no reference sample yet
  // ACQ    | have a reference, looking for a +/-1 step to set direction
  // TRACK  | direction known, counting consistent steps toward lock
  // LOCKED | sequence tracked; mismatches raise err
  typedef enum logic [1:0] {HUNT, ACQ, TRACK, LOCKED} state_t;

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] MAX    = '1;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO   = '0;
  localparam logic [MC_W-1:0]  MC_ONE = MC_W'(1);
  localparam logic [MC_W-1:0]  MC_LCK = MC_W'(LOCK_CNT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic             dir, dir_nxt;
  logic [MC_W-1:0]  match_cnt, match_nxt;
  logic             err_nxt, peak_nxt, trough_nxt;
  logic [CNT_W-1:0] pc_nxt, ec_nxt;

  logic [WIDTH-1:0] exp_val;
  logic             exp_dir;
  logic             match, acq_up, acq_dn;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HUNT;
      prev         <= '0;
      dir          <= 1'b0;
      match_cnt    <= '0;
      err          <= 1'b0;
      peak         <= 1'b0;
      trough       <= 1'b0;
      period_count <= '0;
      err_count    <= '0;
    end else begin
      state        <= state_nxt;
      prev         <= prev_nxt;
      dir          <= dir_nxt;
      match_cnt    <= match_nxt;
      err          <= err_nxt;
      peak         <= peak_nxt;
      trough       <= trough_nxt;
      period_count <= pc_nxt;
      err_count    <= ec_nxt;
    end
  end

  // Next value predicted from the last accepted sample, including turnaround at the ends.
  always_comb begin
    exp_val = prev + ONE;
    exp_dir = 1'b1;
    if (dir) begin
      if (prev == MAX) begin
        exp_val = MAX - ONE;
        exp_dir = 1'b0;
      end
    end else if (prev == ZERO) begin
      exp_val = ONE;
      exp_dir = 1'b1;
    end else begin
      exp_val = prev - ONE;
      exp_dir = 1'b0;
    end
  end

  assign match  = (din == exp_val);
  assign acq_up = (prev != MAX)  && (din == prev + ONE);
  assign acq_dn = (prev != ZERO) && (din == prev - ONE);

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    dir_nxt   = dir;
    match_nxt = match_cnt;
    if (en) begin
      prev_nxt = din;
      unique case (state)
        HUNT: state_nxt = ACQ;
        ACQ: begin
          if (acq_up || acq_dn) begin
            dir_nxt   = acq_up;
            match_nxt = MC_ONE;
            state_nxt = (LOCK_CNT == 1) ? LOCKED : TRACK;
          end else begin
            match_nxt = '0;
          end
        end
        TRACK: begin
          if (match) begin
            dir_nxt   = exp_dir;
            match_nxt = match_cnt + MC_ONE;
            if (match_cnt + MC_ONE == MC_LCK) state_nxt = LOCKED;
          end else begin
            match_nxt = '0;
            state_nxt = ACQ;
          end
        end
        LOCKED: begin
          if (match) begin
            dir_nxt = exp_dir;
          end else begin
            match_nxt = '0;
            state_nxt = ACQ;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    err_nxt    = 1'b0;
    peak_nxt   = 1'b0;
    trough_nxt = 1'b0;
    pc_nxt     = period_count;
    ec_nxt     = err_count;
    if (en && state == LOCKED) begin
      if (match) begin
        peak_nxt   = (din == MAX);
        trough_nxt = (din == ZERO);
        if (din == ZERO && !(&period_count)) pc_nxt = period_count + CNT_W'(1);
      end else begin
        err_nxt = 1'b1;
        if (!(&err_count)) ec_nxt = err_count + CNT_W'(1);
      end
    end
  end

  assign locked = (state == LOCKED);
  assign dir_up = dir;

endmodule
